// File: rtl/float_div.sv
// ==========================================================================
// float_div : sequential fp16 divider, restoring radix-2, one quotient bit/clk
// Rev 1.0
// ==========================================================================
`default_nettype none

module float_div #(
  parameter int QBITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        NaN,
  output logic        precisionLost,
  output logic        divByZero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] c_last_bit = 4'(QBITS - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [11:0]        rem_q, rem_d;
  logic [10:0]        div_q, div_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [4:0]         ex1_q, ex1_d, ex2_q, ex2_d;
  logic               sign_q, sign_d;
  logic [15:0]        result_q, result_d;
  logic               ovf_q, ovf_d, zero_q, zero_d, nan_q, nan_d;
  logic               plost_q, plost_d, dbz_q, dbz_d;

  // Subnormal operands (exponent 0) are deliberately decoded as zero.
  logic w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2, w_sign;
  assign w_zero1 = (num1[14:10] == 5'd0);
  assign w_zero2 = (num2[14:10] == 5'd0);
  assign w_inf1  = (&num1[14:10]) & ~(|num1[9:0]);
  assign w_inf2  = (&num2[14:10]) & ~(|num2[9:0]);
  assign w_nan1  = (&num1[14:10]) & (|num1[9:0]);
  assign w_nan2  = (&num2[14:10]) & (|num2[9:0]);
  assign w_sign  = num1[15] ^ num2[15];

  logic w_special;
  assign w_special = w_nan1 | w_nan2 | w_inf1 | w_inf2 | w_zero1 | w_zero2;

  logic        w_ge;
  logic [11:0] w_rem_sub, w_rem_sel;
  assign w_ge      = (rem_q >= {1'b0, div_q});
  assign w_rem_sub = rem_q - {1'b0, div_q};
  assign w_rem_sel = w_ge ? w_rem_sub : rem_q;

  // Quotient below 1.0 means one extra left shift, hence the exponent decrement.
  logic signed [6:0] w_exp;
  logic [9:0]        w_frac;
  logic              w_dropped;
  assign w_exp = $signed({2'b00, ex1_q}) - $signed({2'b00, ex2_q}) + 7'sd15
                 - (quo_q[QBITS-1] ? 7'sd0 : 7'sd1);
  assign w_frac    = quo_q[QBITS-1] ? quo_q[10:1] : quo_q[9:0];
  assign w_dropped = quo_q[QBITS-1] & quo_q[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    ex1_d    = ex1_q;
    ex2_d    = ex2_q;
    sign_d   = sign_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    nan_d    = nan_q;
    plost_d  = plost_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = w_sign;
          ex1_d  = num1[14:10];
          ex2_d  = num2[14:10];
          if (w_special) begin
            state_d = S_DONE;
            ovf_d   = 1'b0;
            zero_d  = 1'b0;
            nan_d   = 1'b0;
            plost_d = 1'b0;
            dbz_d   = 1'b0;
            if (w_nan1 | w_nan2 | (w_zero1 & w_zero2) | (w_inf1 & w_inf2)) begin
              result_d = 16'h7E00;
              nan_d    = 1'b1;
            end else if (w_inf1) begin
              result_d = {w_sign, 5'h1F, 10'h000};
              ovf_d    = 1'b1;
            end else if (w_zero2) begin
              result_d = {w_sign, 5'h1F, 10'h000};
              dbz_d    = 1'b1;
            end else begin
              result_d = {w_sign, 15'h0000};
              zero_d   = 1'b1;
            end
          end else begin
            state_d = S_DIV;
            cnt_d   = 4'd0;
            rem_d   = {1'b0, 1'b1, num1[9:0]};
            div_d   = {1'b1, num2[9:0]};
            quo_d   = '0;
          end
        end
      end

      S_DIV: begin
        quo_d = {quo_q[QBITS-2:0], w_ge};
        rem_d = w_rem_sel << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == c_last_bit) state_d = S_NORM;
      end

      S_NORM: begin
        state_d = S_DONE;
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        nan_d   = 1'b0;
        plost_d = 1'b0;
        dbz_d   = 1'b0;
        if (w_exp >= 7'sd31) begin
          result_d = {sign_q, 5'h1F, 10'h000};
          ovf_d    = 1'b1;
        end else if (w_exp <= 7'sd0) begin
          result_d = {sign_q, 15'h0000};
          zero_d   = 1'b1;
          plost_d  = 1'b1;
        end else begin
          result_d = {sign_q, w_exp[4:0], w_frac};
          plost_d  = w_dropped | (|rem_q);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rem_q    <= 12'd0;
      div_q    <= 11'd0;
      quo_q    <= '0;
      ex1_q    <= 5'd0;
      ex2_q    <= 5'd0;
      sign_q   <= 1'b0;
      result_q <= 16'd0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      nan_q    <= 1'b0;
      plost_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      ex1_q    <= ex1_d;
      ex2_q    <= ex2_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      nan_q    <= nan_d;
      plost_q  <= plost_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result        = result_q;
  assign overflow      = ovf_q;
  assign zero          = zero_q;
  assign NaN           = nan_q;
  assign precisionLost = plost_q;
  assign divByZero     = dbz_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_float_div.sv
// ==========================================================================
// tb_float_div : scoreboard bench for float_div with directed fp16 vectors
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_float_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num1 = 16'h0;
  logic [15:0] num2 = 16'h0;
  logic [15:0] result;
  logic        overflow, zero, NaN, precisionLost, divByZero, busy, done;
  logic [4:0]  flags;

  // Flag vector order: {overflow, zero, NaN, precisionLost, divByZero}
  assign flags = {overflow, zero, NaN, precisionLost, divByZero};

  float_div dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num1          (num1),
    .num2          (num2),
    .result        (result),
    .overflow      (overflow),
    .zero          (zero),
    .NaN           (NaN),
    .precisionLost (precisionLost),
    .divByZero     (divByZero),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fl;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t m_e;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        check("result", {16'h0, result}, {16'h0, m_e.res});
        check("flags", {27'h0, flags}, {27'h0, m_e.fl});
        check("latency", cyc, m_e.due);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [4:0] f, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    num1  = a;
    num2  = b;
    e.res = r;
    e.fl  = f;
    e.due = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got done=0 expected done=1");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_result", {16'h0, result}, 32'h0);
    check("reset_flags", {27'h0, flags}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;

    // Normal path, including a busy probe mid-division
    issue(16'h4200, 16'h3E00, 16'h4000, 5'b00000, 14);
    repeat (4) @(negedge clk);
    check("busy_mid_div", {31'h0, busy}, 32'h1);
    drain();
    issue(16'h3C00, 16'h4200, 16'h3555, 5'b00010, 14); drain();
    issue(16'hC200, 16'h3E00, 16'hC000, 5'b00000, 14); drain();
    issue(16'h4500, 16'h4000, 16'h4100, 5'b00000, 14); drain();

    // Special cases take one cycle
    issue(16'h4000, 16'h0000, 16'h7C00, 5'b00001, 1); drain();
    issue(16'h0000, 16'h0000, 16'h7E00, 5'b00100, 1); drain();
    issue(16'h7E00, 16'h4000, 16'h7E00, 5'b00100, 1); drain();
    issue(16'h7C00, 16'h7C00, 16'h7E00, 5'b00100, 1); drain();
    issue(16'h7C00, 16'hC000, 16'hFC00, 5'b10000, 1); drain();
    issue(16'h3C00, 16'h7C00, 16'h0000, 5'b01000, 1); drain();
    issue(16'h8000, 16'h4000, 16'h8000, 5'b01000, 1); drain();
    issue(16'h0001, 16'h4000, 16'h0000, 5'b01000, 1); drain();

    // Exponent range limits
    issue(16'h7BFF, 16'h3800, 16'h7C00, 5'b10000, 14); drain();
    issue(16'h0400, 16'h4000, 16'h0000, 5'b01010, 14); drain();

    // A start during DIV must be ignored
    issue(16'h4500, 16'h4000, 16'h4100, 5'b00000, 14);
    repeat (3) @(negedge clk);
    start = 1'b1;
    num1  = 16'h4200;
    num2  = 16'h3C00;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Reset mid-operation: outputs clear at once, no done afterwards
    @(negedge clk);
    start = 1'b1;
    num1  = 16'h3C00;
    num2  = 16'h4200;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_result", {16'h0, result}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_done", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'h4200, 16'h3E00, 16'h4000, 5'b00000, 14); drain();

    // Back-to-back: start in the cycle after done; previous result is held
    issue(16'h3C00, 16'h4200, 16'h3555, 5'b00010, 14);
    wait_done();
    issue(16'h4500, 16'h4000, 16'h4100, 5'b00000, 14);
    #1;
    check("held_result", {16'h0, result}, 32'h3555);
    check("held_flags", {27'h0, flags}, 32'h2);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
